// File: rtl/snoopy_bus_arbiter.sv
// Round-robin arbiter for the shared snoopy lock bus.
// Latches the owner's key and checks it against the other lock tables.
module snoopy_bus_arbiter #(
  parameter int NUM_PROCS     = 4,
  parameter int MAX_LOCK_KEYS = 4,
  parameter int GRANT_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PROCS-1:0]    snoopy_bus_request,
  input  logic [NUM_PROCS-1:0]    snoopy_bus_release,
  input  logic [NUM_PROCS-1:0]    snoop_check_req,
  input  logic [32*NUM_PROCS-1:0] snoopy_bus_key_to_be_locked,
  input  logic [32*MAX_LOCK_KEYS*NUM_PROCS-1:0] locked_key_table,
  output logic [NUM_PROCS-1:0]    snoopy_bus_grant,
  output logic [NUM_PROCS-1:0]    add_conflict_snoopy_to_proc,
  output logic                    bus_busy,
  output logic [$clog2(NUM_PROCS)-1:0] bus_owner,
  output logic [31:0]             snoop_key,
  output logic                    protocol_error
);

  localparam int W  = $clog2(NUM_PROCS);
  localparam int TW = $clog2(GRANT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    CHECK,
    HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_PROCS-1:0] grant_q, grant_d;
  logic [NUM_PROCS-1:0] conf_q, conf_d;
  logic [W-1:0]         owner_q, owner_d;
  logic [W-1:0]         rr_q, rr_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [31:0]          key_q, key_d;
  logic                 err_q, err_d;

  logic                 found;
  logic [W-1:0]         pick;
  logic                 hit;
  logic [31:0]          cur_key;
  logic [31:0]          entry;
  logic [NUM_PROCS-1:0] own;
  logic                 rel;
  logic                 chk;
  logic                 bad;

  function automatic logic [W-1:0] wrap_add(
    input logic [W-1:0] b,
    input int           off
  );
    int j;
    j = int'(b) + off;
    if (j >= NUM_PROCS) j = j - NUM_PROCS;
    return W'(j);
  endfunction

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_PROCS; i++) begin
      if (!found && snoopy_bus_request[wrap_add(rr_q, i)]) begin
        found = 1'b1;
        pick  = wrap_add(rr_q, i);
      end
    end
  end

  // All-ones entries are empty slots; the owner's own table is skipped.
  always_comb begin
    hit     = 1'b0;
    entry   = '0;
    cur_key = snoopy_bus_key_to_be_locked[32*int'(owner_q) +: 32];
    for (int p = 0; p < NUM_PROCS; p++) begin
      for (int k = 0; k < MAX_LOCK_KEYS; k++) begin
        entry = locked_key_table[32*(p*MAX_LOCK_KEYS+k) +: 32];
        if (p != int'(owner_q) && entry == cur_key && entry != '1)
          hit = 1'b1;
      end
    end
  end

  always_comb begin
    own          = '0;
    own[owner_q] = 1'b1;
    rel = |(snoopy_bus_release & own);
    chk = |(snoop_check_req & own);
    if (state_q == IDLE)
      bad = (|snoop_check_req) | (|(snoopy_bus_release & ~own));
    else
      bad = (|(snoop_check_req & ~own)) |
            (|(snoopy_bus_release & ~own));
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    conf_d  = conf_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    key_d   = key_q;
    err_d   = err_q | bad;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          owner_d       = pick;
          timer_d       = '0;
          state_d       = GRANT;
        end
      end
      GRANT, CHECK, HOLD: begin
        if (rel) begin
          grant_d = '0;
          conf_d  = '0;
          rr_d    = wrap_add(owner_q, 1);
          state_d = IDLE;
        end else if (state_q == GRANT) begin
          if (chk) begin
            key_d           = cur_key;
            conf_d          = '0;
            conf_d[owner_q] = hit;
            state_d         = CHECK;
          end else if (timer_q == TW'(GRANT_TIMEOUT - 1)) begin
            grant_d = '0;
            rr_d    = wrap_add(owner_q, 1);
            state_d = IDLE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end else if (state_q == CHECK) begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      conf_q  <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      timer_q <= '0;
      key_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      conf_q  <= conf_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      key_q   <= key_d;
      err_q   <= err_d;
    end
  end

  assign snoopy_bus_grant            = grant_q;
  assign add_conflict_snoopy_to_proc = conf_q;
  assign bus_busy                    = |grant_q;
  assign bus_owner                   = owner_q;
  assign snoop_key                   = key_q;
  assign protocol_error              = err_q;

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Directed bench for snoopy_bus_arbiter.
// Checks arbitration order, conflicts, timeout, errors, reset.
module tb_snoopy_bus_arbiter;

  localparam int N = 4;
  localparam int M = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    rel;
  logic [N-1:0]    ck;
  logic [32*N-1:0] keys;
  logic [32*M*N-1:0] tbl;
  logic [N-1:0]    grant;
  logic [N-1:0]    conf;
  logic            busy;
  logic [1:0]      owner;
  logic [31:0]     skey;
  logic            perr;

  int checks = 0;
  int errors = 0;
  int n;
  int order [6];

  snoopy_bus_arbiter #(
    .NUM_PROCS    (N),
    .MAX_LOCK_KEYS(M),
    .GRANT_TIMEOUT(16)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .snoopy_bus_request         (req),
    .snoopy_bus_release         (rel),
    .snoop_check_req            (ck),
    .snoopy_bus_key_to_be_locked(keys),
    .locked_key_table           (tbl),
    .snoopy_bus_grant           (grant),
    .add_conflict_snoopy_to_proc(conf),
    .bus_busy                   (busy),
    .bus_owner                  (owner),
    .snoop_key                  (skey),
    .protocol_error             (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tbl(input int p, input int k, input logic [31:0] v);
    tbl[32*(p*M+k) +: 32] = v;
  endtask

  task automatic set_key(input int p, input logic [31:0] v);
    keys[32*p +: 32] = v;
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    rel   = '0;
    ck    = '0;
    keys  = '0;
    tbl   = '1;
    tick();
    tick();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_conf",  64'(conf),  64'h0);
    chk("rst_busy",  64'(busy),  64'h0);
    chk("rst_owner", 64'(owner), 64'h0);
    chk("rst_key",   64'(skey),  64'h0);
    chk("rst_err",   64'(perr),  64'h0);
    reset = 1'b1;
    tick();

    // single request, no conflict
    req = 4'b0010;
    set_key(1, 32'h10);
    tick();
    chk("t1_grant", 64'(grant), 64'h2);
    chk("t1_busy",  64'(busy),  64'h1);
    chk("t1_owner", 64'(owner), 64'h1);
    ck = 4'b0010;
    tick();
    ck = '0;
    chk("t1_key",  64'(skey), 64'h10);
    chk("t1_conf", 64'(conf), 64'h0);
    chk("t1_hold", 64'(grant), 64'h2);
    tick();
    rel = 4'b0010;
    req = '0;
    tick();
    rel = '0;
    chk("t1_rel_grant", 64'(grant), 64'h0);
    chk("t1_rel_busy",  64'(busy),  64'h0);

    // conflict with another table, held across table change
    set_tbl(0, 3, 32'h55);
    set_tbl(2, 0, 32'h55);
    set_key(2, 32'h55);
    req = 4'b0100;
    tick();
    chk("t2_grant", 64'(grant), 64'h4);
    ck = 4'b0100;
    tick();
    ck = '0;
    chk("t2_conf", 64'(conf), 64'h4);
    set_tbl(0, 3, 32'h0);
    tick();
    tick();
    chk("t2_conf_held", 64'(conf), 64'h4);
    rel = 4'b0100;
    req = '0;
    tick();
    rel = '0;
    chk("t2_rel_conf",  64'(conf),  64'h0);
    chk("t2_rel_grant", 64'(grant), 64'h0);

    // all-ones key never matches empty slots; release from CHECK
    set_key(3, 32'hFFFF_FFFF);
    req = 4'b1000;
    tick();
    chk("t2b_grant", 64'(grant), 64'h8);
    ck = 4'b1000;
    tick();
    ck = '0;
    chk("t2b_conf", 64'(conf), 64'h0);
    rel = 4'b1000;
    req = '0;
    tick();
    rel = '0;
    chk("t2b_rel", 64'(grant), 64'h0);
    tbl = '1;

    // round robin among 0,1,3
    req = 4'b1011;
    for (int t = 0; t < 6; t++) begin
      n = 0;
      while (grant == '0 && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("rr_gap%0d", t), 64'(n), 64'd1);
      order[t] = int'(owner);
      tick();
      tick();
      tick();
      rel = grant;
      tick();
      rel = '0;
      chk($sformatf("rr_rel%0d", t), 64'(grant), 64'h0);
    end
    req = '0;
    chk("rr_o0", 64'(order[0]), 64'd0);
    chk("rr_o1", 64'(order[1]), 64'd1);
    chk("rr_o2", 64'(order[2]), 64'd3);
    chk("rr_o3", 64'(order[3]), 64'd0);
    chk("rr_o4", 64'(order[4]), 64'd1);
    chk("rr_o5", 64'(order[5]), 64'd3);
    tick();

    // grant timeout
    req = 4'b0001;
    tick();
    chk("to_grant", 64'(grant), 64'h1);
    req = 4'b0011;
    n = 0;
    while (grant[0] && n < 40) begin
      tick();
      n++;
    end
    chk("to_len", 64'(n), 64'd16);
    tick();
    chk("to_next", 64'(grant), 64'h2);
    chk("to_err",  64'(perr),  64'h0);
    rel = 4'b0010;
    req = 4'b0001;
    tick();
    rel = '0;
    tick();
    chk("pe_grant", 64'(grant), 64'h1);

    // release from a non-owner
    rel = 4'b1000;
    req = '0;
    tick();
    rel = '0;
    chk("pe_err",  64'(perr),  64'h1);
    chk("pe_keep", 64'(grant), 64'h1);
    rel = 4'b0001;
    tick();
    rel = '0;
    chk("pe_rel", 64'(grant), 64'h0);

    // async reset while holding a conflict
    set_tbl(1, 0, 32'hABCD);
    set_key(2, 32'hABCD);
    req = 4'b0100;
    tick();
    chk("ar_grant", 64'(grant), 64'h4);
    ck = 4'b0100;
    tick();
    ck = '0;
    tick();
    chk("ar_conf", 64'(conf), 64'h4);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_grant0", 64'(grant), 64'h0);
    chk("ar_conf0",  64'(conf),  64'h0);
    chk("ar_busy0",  64'(busy),  64'h0);
    chk("ar_key0",   64'(skey),  64'h0);
    chk("ar_err0",   64'(perr),  64'h0);
    req = 4'b1111;
    tick();
    reset = 1'b1;
    tick();
    chk("ar_first", 64'(grant), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
